// File: rtl/control_pipe.sv
// Pipeline control-bundle registers (ID/EX, EX/MEM, MEM/WB) with load-use
// stall detection and branch/jump flush of the IF/ID stage.
module control_pipe #(
   parameter int unsigned REG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       WB_in,
   input  logic [1:0]       MEM_in,
   input  logic [3:0]       EX_in,
   input  logic             jump_in,
   input  logic             branch_in,
   input  logic             branch_taken_in,
   input  logic [REG_W-1:0] rs_id,
   input  logic [REG_W-1:0] rt_id,
   input  logic [REG_W-1:0] rd_id,
   output logic [3:0]       EX_ex,
   output logic [1:0]       MEM_ex,
   output logic [1:0]       MEM_mem,
   output logic [1:0]       WB_wb,
   output logic [REG_W-1:0] wreg_wb,
   output logic [REG_W-1:0] wreg_mem,
   output logic             stall_out,
   output logic             flush_out
);

   logic [1:0]       wb_ex;
   logic [REG_W-1:0] rt_ex;
   logic [REG_W-1:0] rd_ex;
   logic [1:0]       wb_mem;
   logic             load_use;
   logic             squash;

   // A load in EX whose target is read by the instruction in ID must wait one cycle.
   always_comb begin
      load_use = MEM_ex[1] & (rt_ex != '0) & ((rt_ex == rs_id) | (rt_ex == rt_id));
      // Stall wins over flush: the ID instruction is re-presented next cycle.
      flush_out = (jump_in | (branch_in & branch_taken_in)) & ~load_use;
      stall_out = load_use;
      squash    = load_use | flush_out;
   end

   // Stage registers; only ID/EX can take a bubble, later stages always advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_ex    <= '0;
         MEM_ex   <= '0;
         EX_ex    <= '0;
         rt_ex    <= '0;
         rd_ex    <= '0;
         wb_mem   <= '0;
         MEM_mem  <= '0;
         wreg_mem <= '0;
         WB_wb    <= '0;
         wreg_wb  <= '0;
      end else begin
         if (squash) begin
            wb_ex  <= '0;
            MEM_ex <= '0;
            EX_ex  <= '0;
            rt_ex  <= '0;
            rd_ex  <= '0;
         end else begin
            wb_ex  <= WB_in;
            MEM_ex <= MEM_in;
            EX_ex  <= EX_in;
            rt_ex  <= rt_id;
            rd_ex  <= rd_id;
         end
         wb_mem   <= wb_ex;
         MEM_mem  <= MEM_ex;
         wreg_mem <= EX_ex[3] ? rd_ex : rt_ex;
         WB_wb    <= wb_mem;
         wreg_wb  <= wreg_mem;
      end
   end

endmodule

// File: tb/tb_control_pipe.sv
// Directed self-checking bench for control_pipe.
module tb_control_pipe;

   localparam int unsigned REG_W = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       WB_in;
   logic [1:0]       MEM_in;
   logic [3:0]       EX_in;
   logic             jump_in;
   logic             branch_in;
   logic             branch_taken_in;
   logic [REG_W-1:0] rs_id;
   logic [REG_W-1:0] rt_id;
   logic [REG_W-1:0] rd_id;
   logic [3:0]       EX_ex;
   logic [1:0]       MEM_ex;
   logic [1:0]       MEM_mem;
   logic [1:0]       WB_wb;
   logic [REG_W-1:0] wreg_wb;
   logic [REG_W-1:0] wreg_mem;
   logic             stall_out;
   logic             flush_out;

   int n_cmp = 0;
   int n_err = 0;

   control_pipe #(.REG_W(REG_W)) dut (
      .clk(clk), .reset(reset),
      .WB_in(WB_in), .MEM_in(MEM_in), .EX_in(EX_in),
      .jump_in(jump_in), .branch_in(branch_in), .branch_taken_in(branch_taken_in),
      .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
      .EX_ex(EX_ex), .MEM_ex(MEM_ex), .MEM_mem(MEM_mem), .WB_wb(WB_wb),
      .wreg_wb(wreg_wb), .wreg_mem(wreg_mem),
      .stall_out(stall_out), .flush_out(flush_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present an ID-stage instruction; settles 1 time unit for combinational checks.
   task automatic drive(input logic [1:0] wb, input logic [1:0] mem, input logic [3:0] ex,
                        input logic j, input logic b, input logic bt,
                        input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                        input logic [REG_W-1:0] rd);
      WB_in = wb; MEM_in = mem; EX_in = ex;
      jump_in = j; branch_in = b; branch_taken_in = bt;
      rs_id = rs; rt_id = rt; rd_id = rd;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      drive(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
   endtask

   initial begin
      // Reset with busy inputs
      reset = 1'b1;
      drive(2'b11, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 5'd7, 5'd7, 5'd7);
      tick();
      tick();
      check("rst_EX_ex",    32'(EX_ex),    32'h0);
      check("rst_MEM_ex",   32'(MEM_ex),   32'h0);
      check("rst_MEM_mem",  32'(MEM_mem),  32'h0);
      check("rst_WB_wb",    32'(WB_wb),    32'h0);
      check("rst_wreg_mem", 32'(wreg_mem), 32'h0);
      check("rst_wreg_wb",  32'(wreg_wb),  32'h0);
      reset = 1'b0;

      // R-type latency
      drive(2'b10, 2'b00, 4'b1100, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd5);
      check("rt_stall", 32'(stall_out), 32'h0);
      check("rt_flush", 32'(flush_out), 32'h0);
      tick();
      check("rt_EX_ex_p1",    32'(EX_ex),    32'hC);
      check("rt_wreg_mem_p1", 32'(wreg_mem), 32'h0);
      nop();
      tick();
      check("rt_MEM_mem_p2",  32'(MEM_mem),  32'h0);
      check("rt_wreg_mem_p2", 32'(wreg_mem), 32'h5);
      check("rt_WB_wb_p2",    32'(WB_wb),    32'h0);
      tick();
      check("rt_WB_wb_p3",   32'(WB_wb),   32'h2);
      check("rt_wreg_wb_p3", 32'(wreg_wb), 32'h5);

      // lw followed by dependent add: one stall cycle
      drive(2'b01, 2'b10, 4'b0001, 1'b0, 1'b0, 1'b0, 5'd3, 5'd8, 5'd0);
      tick();
      check("lw_MEM_ex", 32'(MEM_ex), 32'h2);
      drive(2'b10, 2'b00, 4'b1100, 1'b0, 1'b0, 1'b0, 5'd8, 5'd4, 5'd9);
      check("lu_stall", 32'(stall_out), 32'h1);
      check("lu_flush", 32'(flush_out), 32'h0);
      tick();
      check("lu_bub_EX_ex",  32'(EX_ex),    32'h0);
      check("lu_bub_MEM_ex", 32'(MEM_ex),   32'h0);
      check("lw_wreg_mem",   32'(wreg_mem), 32'h8);
      check("lu_stall_once", 32'(stall_out), 32'h0);
      tick();
      check("lu_issue_EX_ex", 32'(EX_ex),   32'hC);
      check("lw_WB_wb",       32'(WB_wb),   32'h1);
      check("lw_wreg_wb",     32'(wreg_wb), 32'h8);
      check("bub_MEM_mem",    32'(MEM_mem), 32'h0);
      nop();
      tick();
      check("add_wreg_mem", 32'(wreg_mem), 32'h9);

      // beq taken / not taken
      drive(2'b00, 2'b00, 4'b0010, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd0);
      check("beqT_flush", 32'(flush_out), 32'h1);
      tick();
      check("beqT_EX_ex", 32'(EX_ex), 32'h0);
      drive(2'b00, 2'b00, 4'b0010, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0);
      check("beqN_flush", 32'(flush_out), 32'h0);
      tick();
      check("beqN_EX_ex", 32'(EX_ex), 32'h2);

      // jump coincident with load-use: stall first, flush next
      drive(2'b01, 2'b10, 4'b0001, 1'b0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0);
      tick();
      drive(2'b00, 2'b00, 4'b0100, 1'b1, 1'b0, 1'b0, 5'd7, 5'd0, 5'd0);
      check("jlu_stall", 32'(stall_out), 32'h1);
      check("jlu_flush", 32'(flush_out), 32'h0);
      tick();
      check("jlu_stall2", 32'(stall_out), 32'h0);
      check("jlu_flush2", 32'(flush_out), 32'h1);
      tick();
      check("jmp_EX_ex", 32'(EX_ex), 32'h0);

      // lw with rt=0 never stalls
      drive(2'b01, 2'b10, 4'b0001, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      check("lw0_MEM_ex", 32'(MEM_ex), 32'h2);
      drive(2'b00, 2'b01, 4'b0001, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0);
      check("lw0_stall", 32'(stall_out), 32'h0);
      tick();

      // sw in MEM then reset mid-flight
      nop();
      tick();
      check("sw_MEM_mem", 32'(MEM_mem), 32'h1);
      drive(2'b10, 2'b11, 4'b1100, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd6);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      nop();
      check("mrst_EX_ex",    32'(EX_ex),    32'h0);
      check("mrst_MEM_ex",   32'(MEM_ex),   32'h0);
      check("mrst_MEM_mem",  32'(MEM_mem),  32'h0);
      check("mrst_WB_wb",    32'(WB_wb),    32'h0);
      check("mrst_wreg_mem", 32'(wreg_mem), 32'h0);
      check("mrst_wreg_wb",  32'(wreg_wb),  32'h0);
      check("mrst_stall",    32'(stall_out), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/control_pipe.md
CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 The block SHALL have parameter REG_W, default 5, meaning the register-specifier width.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port WB_in, input, 2, the WB control bundle from the Control decoder in ID.
REQ-005 The block SHALL have port MEM_in, input, 2, the MEM bundle from Control in ID; bit1 = MemRead, bit0 = MemWrite.
REQ-006 The block SHALL have port EX_in, input, 4, the EX bundle from Control in ID; bit3 = RegDst.
REQ-007 The block SHALL have port jump_in, input, 1, jump decoded in ID.
REQ-008 The block SHALL have port branch_in, input, 1, branch decoded in ID.
REQ-009 The block SHALL have port branch_taken_in, input, 1, ID-stage comparator result.
REQ-010 The block SHALL have ports rs_id, rt_id and rd_id, input, REG_W each, the ID-stage register specifiers.
REQ-011 The block SHALL have port EX_ex, output, 4, the EX bundle in the EX stage.
REQ-012 The block SHALL have port MEM_ex, output, 2, the MEM bundle in the EX stage.
REQ-013 The block SHALL have port MEM_mem, output, 2, the MEM bundle in the MEM stage.
REQ-014 The block SHALL have ports WB_wb, output, 2, and wreg_wb, output, REG_W, the WB bundle and destination register in the WB stage.
REQ-015 The block SHALL have port wreg_mem, output, REG_W, the destination register in the MEM stage.
REQ-016 The block SHALL have ports stall_out and flush_out, output, 1 each: hold PC and IF/ID, and squash IF/ID, respectively.

Function
REQ-017 The block SHALL hold three register stages: ID/EX {WB,MEM,EX,rt,rd}, EX/MEM {WB,MEM,wreg}, MEM/WB {WB,wreg}.
REQ-018 Control from ID at edge N SHALL appear on EX_ex/MEM_ex after N, on MEM_mem after N+1, and on WB_wb after N+2: 1, 2 and 3 cycle latency.
REQ-019 A bubble SHALL be all-zero WB, MEM and EX bits with rt = rd = 0.
REQ-020 load_use SHALL equal MEM_ex[1] & (rt_ex != 0) & ((rt_ex == rs_id) | (rt_ex == rt_id)).
REQ-021 stall_out SHALL equal load_use, combinational from current state and inputs.
REQ-022 flush_out SHALL equal (jump_in | (branch_in & branch_taken_in)) & ~load_use; stall has priority because the ID instruction is re-presented next cycle.
REQ-023 On each edge with stall_out or flush_out = 1, ID/EX SHALL load a bubble; otherwise it SHALL load the ID inputs.
REQ-024 EX/MEM SHALL always advance from ID/EX with wreg = EX[3] ? rd : rt; MEM/WB SHALL always advance from EX/MEM. Later stages never stall.
REQ-025 wreg = 0 SHALL be carried unchanged; no masking of WB bits is performed.
REQ-026 Back-to-back load-use SHALL produce exactly one stall cycle: the bubble clears MEM_ex[1] on the next cycle.

Reset
REQ-027 While reset = 1 at an edge, all stage registers SHALL become bubbles, so EX_ex, MEM_ex, MEM_mem, WB_wb, wreg_mem and wreg_wb = 0, overriding stall and flush.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight control; stall_out is 0 in the cycle after reset.

Verification
REQ-029 R-type: WB_in=10, MEM_in=00, EX_in=1100, rd_id=5 -> EX_ex=1100 at +1, MEM_mem=00 and wreg_mem=5 at +2, WB_wb=10 and wreg_wb=5 at +3.
REQ-030 lw: WB=01, MEM=10, EX=0001, rt=8, then next ID rs_id=8 -> stall_out=1 for one cycle; EX_ex=0000 and MEM_ex=00 bubble follows; the re-presented instruction issues after.
REQ-031 beq with branch_taken_in=1 -> flush_out=1 and EX_ex=0000 next cycle; with branch_taken_in=0 -> flush_out=0 and EX_ex=0010.
REQ-032 jump_in=1 coincident with load_use=1 -> stall_out=1, flush_out=0; the following cycle has flush_out=1.
REQ-033 lw with rt_ex=0 and rs_id=0 -> stall_out=0.
REQ-034 sw in flight (MEM_mem=01) then reset=1 for one edge -> all outputs 0 next cycle.
